// File: rtl/gpr_regfile.sv
`default_nettype none
// ============================================================================
// Module   : gpr_regfile
// Brief    : 31x32 GPR file with one commit write port, two combinational
//            read ports and a handshaked debug port that defers to commit
//            writes and raises dbg_hold_o after DEFER_MAX deferred cycles.
//            Optional feature macro: REGFILE_BYPASS_EN (write-to-read forwarding).
// Revision : 1.0 - initial release
// ============================================================================
module gpr_regfile #(
    parameter int DEFER_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr1_i,
    output logic [31:0] rdata1_o,
    input  logic [4:0]  raddr2_i,
    output logic [31:0] rdata2_o,
    input  logic        dbg_req_i,
    input  logic        dbg_we_i,
    input  logic [4:0]  dbg_addr_i,
    input  logic [31:0] dbg_wdata_i,
    output logic        dbg_ack_o,
    output logic [31:0] dbg_rdata_o,
    output logic        dbg_hold_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DEFER = 2'd1,
        S_ACK   = 2'd2
    } state_t;

    localparam logic [3:0] c_DEFER_MAX = 4'(DEFER_MAX);
    localparam logic [3:0] c_CNT_SAT   = 4'd15;

    logic [31:0] r_regs [1:31];
    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [4:0]  r_dbg_addr;
    logic [31:0] r_dbg_wdata;
    logic [31:0] r_dbg_rdata;
    logic        r_hold;

    logic        w_commit_we;
    logic        w_dbg_we;
    logic [4:0]  w_dbg_waddr;
    logic [31:0] w_dbg_wdata;
    logic        w_latch;
    logic        w_capture;
    logic [31:0] w_cap_data;
    logic [31:0] w_rd1;
    logic [31:0] w_rd2;

    assign w_commit_we = we_i && (waddr_i != 5'd0);

    // Debug read sees the commit write landing in the same cycle.
    always_comb begin
        w_cap_data = (dbg_addr_i == 5'd0) ? 32'd0 : r_regs[dbg_addr_i];
        if (w_commit_we && (waddr_i == dbg_addr_i)) begin
            w_cap_data = wdata_i;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dbg_we    = 1'b0;
        w_dbg_waddr = r_dbg_addr;
        w_dbg_wdata = r_dbg_wdata;
        w_latch     = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (dbg_req_i) begin
                    if (!dbg_we_i) begin
                        w_capture   = 1'b1;
                        w_state_nxt = S_ACK;
                    end else if (!we_i) begin
                        w_dbg_we    = 1'b1;
                        w_dbg_waddr = dbg_addr_i;
                        w_dbg_wdata = dbg_wdata_i;
                        w_state_nxt = S_ACK;
                    end else begin
                        w_latch     = 1'b1;
                        w_cnt_nxt   = 4'd0;
                        w_state_nxt = S_DEFER;
                    end
                end
            end
            S_DEFER: begin
                if (we_i) begin
                    if (r_cnt != c_CNT_SAT) begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end else begin
                    w_dbg_we    = 1'b1;
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = S_ACK;
                end
            end
            S_ACK: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_dbg_addr  <= 5'd0;
            r_dbg_wdata <= 32'd0;
            r_dbg_rdata <= 32'd0;
            r_hold      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hold  <= (w_state_nxt == S_DEFER) && (w_cnt_nxt >= c_DEFER_MAX);
            if (w_latch) begin
                r_dbg_addr  <= dbg_addr_i;
                r_dbg_wdata <= dbg_wdata_i;
            end
            if (w_capture) begin
                r_dbg_rdata <= w_cap_data;
            end
        end
    end

    // Commit and debug writes are mutually exclusive: debug only writes when we_i=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else if (w_commit_we) begin
            r_regs[waddr_i] <= wdata_i;
        end else if (w_dbg_we && (w_dbg_waddr != 5'd0)) begin
            r_regs[w_dbg_waddr] <= w_dbg_wdata;
        end
    end

    always_comb begin
        w_rd1 = (raddr1_i == 5'd0) ? 32'd0 : r_regs[raddr1_i];
        w_rd2 = (raddr2_i == 5'd0) ? 32'd0 : r_regs[raddr2_i];
`ifdef REGFILE_BYPASS_EN
        if (w_commit_we && (waddr_i == raddr1_i)) begin
            w_rd1 = wdata_i;
        end
        if (w_commit_we && (waddr_i == raddr2_i)) begin
            w_rd2 = wdata_i;
        end
`else
`endif
    end

    assign rdata1_o    = w_rd1;
    assign rdata2_o    = w_rd2;
    assign dbg_ack_o   = (r_state == S_ACK);
    assign dbg_rdata_o = r_dbg_rdata;
    assign dbg_hold_o  = r_hold;

endmodule
`default_nettype wire
